// File: rtl/fp16_softmax_grad.sv
// Softmax backward pass d[i] = y[i]*(g[i] - sum_j y[j]*g[j]) in FP16 (subnormals flushed to zero, RNE rounding).
// Latency ~8+3*IN_OUT_NUM cycles start_op->valid, no backpressure; `FP16_SOFTMAX_GRAD_BUSY_EN adds a busy output.

module fp16_arith #(
    parameter bit IS_MUL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_result,
    output logic        o_valid
);
    logic [15:0] r_a, r_b, r_result;
    logic        r_pend, r_valid;

    function automatic logic [15:0] rnd_pack(input logic s, input int e_in, input logic [10:0] m,
                                             input logic g, input logic st);
        logic [11:0] mr;
        int          e;
        e  = e_in;
        mr = {1'b0, m} + 12'(g & (st | m[0]));
        if (mr[11]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 31) return {s, 5'h1f, 10'h0};
        if (e <= 0) return {s, 15'h0};
        return {s, 5'(e), mr[9:0]};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] x, input logic [15:0] y);
        logic        s;
        logic [21:0] p;
        int          e;
        s = x[15] ^ y[15];
        if (x[14:10] == 5'd0 || y[14:10] == 5'd0) return {s, 15'h0};
        if (x[14:10] == 5'h1f || y[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
        p = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
        e = int'(x[14:10]) + int'(y[14:10]) - 15;
        if (p[21]) return rnd_pack(s, e + 1, p[21:11], p[10], |p[9:0]);
        return rnd_pack(s, e, p[20:10], p[9], |p[8:0]);
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] big, sml;
        logic [26:0] ma, mb;
        logic [27:0] sum, nrm;
        logic        sticky;
        int          d, p, e;
        if (x[14:10] == 5'd0 && y[14:10] == 5'd0) return {x[15] & y[15], 15'h0};
        if (x[14:10] == 5'd0 || y[14:10] == 5'h1f) return y;
        if (y[14:10] == 5'd0 || x[14:10] == 5'h1f) return x;
        if (x[14:0] >= y[14:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        d      = int'(big[14:10]) - int'(sml[14:10]);
        ma     = {1'b1, big[9:0], 16'h0};
        mb     = {1'b1, sml[9:0], 16'h0};
        sticky = 1'b0;
        for (int i = 0; i < 27; i++)
            if (i < d && mb[i]) sticky = 1'b1;
        // Bits shifted past the frame collapse into a sticky LSB so RNE stays exact.
        mb = (mb >> d) | {26'h0, sticky};
        if (big[15] == sml[15]) sum = {1'b0, ma} + {1'b0, mb};
        else sum = {1'b0, ma} - {1'b0, mb};
        if (sum == 28'h0) return 16'h0;
        p = 0;
        for (int i = 0; i < 28; i++)
            if (sum[i]) p = i;
        nrm = sum << (27 - p);
        e   = int'(big[14:10]) + p - 26;
        return rnd_pack(big[15], e, nrm[27:17], nrm[16], |nrm[15:0]);
    endfunction

    // Operands are captured on start; valid drops then rises so the parent can edge-detect.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_pend   <= 1'b0;
            r_valid  <= 1'b0;
        end else if (i_clear) begin
            r_pend  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_pend  <= 1'b1;
            r_valid <= 1'b0;
        end else if (r_pend) begin
            r_result <= IS_MUL ? fmul(r_a, r_b) : fadd(r_a, r_b);
            r_pend   <= 1'b0;
            r_valid  <= 1'b1;
        end
    end

    assign o_result = r_result;
    assign o_valid  = r_valid;
endmodule

module fp16_softmax_grad #(
    parameter int IN_OUT_NUM = 10
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     start_op,
    input  logic                     clear,
    input  logic [IN_OUT_NUM*16-1:0] softmax_val,
    input  logic [IN_OUT_NUM*16-1:0] grad_in_val,
    output logic [IN_OUT_NUM*16-1:0] grad_out_val,
    output logic                     valid
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
    ,
    output logic                     busy
`endif
);
    typedef enum logic [3:0] {
        IDLE, MUL1_S, MUL1_W, ACC_S, ACC_W, SUB_S, SUB_W, MUL2_S, MUL2_W, DONE
    } state_t;

    state_t                  r_state;
    logic [IN_OUT_NUM*16-1:0] r_y, r_g, r_grad_out;
    logic [15:0]             r_acc;
    logic [3:0]              r_cnt;
    logic                    r_valid;
    logic                    r_mul_all_q, r_sub_all_q, r_acc_vld_q;

    logic [IN_OUT_NUM*16-1:0] w_mul_res, w_sub_res;
    logic [IN_OUT_NUM-1:0]   w_mul_vld, w_sub_vld;
    logic [15:0]             w_acc_res, w_acc_b, w_neg_s;
    logic                    w_acc_vld, w_unit_clr, w_mul_start;
    logic                    w_mul_all, w_sub_all, w_mul_edge, w_sub_edge, w_acc_edge;

    assign w_unit_clr  = clear | (r_state == IDLE);
    assign w_mul_start = (r_state == MUL1_S) | (r_state == MUL2_S);
    assign w_neg_s     = {~r_acc[15], r_acc[14:0]};
    assign w_mul_all   = &w_mul_vld;
    assign w_sub_all   = &w_sub_vld;
    assign w_mul_edge  = w_mul_all & ~r_mul_all_q;
    assign w_sub_edge  = w_sub_all & ~r_sub_all_q;
    assign w_acc_edge  = w_acc_vld & ~r_acc_vld_q;

    // The lane multipliers keep their y*g products valid throughout accumulation.
    always_comb begin
        w_acc_b = 16'h0;
        for (int i = 0; i < IN_OUT_NUM; i++)
            if (r_cnt == 4'(i)) w_acc_b = w_mul_res[16*i +: 16];
    end

    for (genvar i = 0; i < IN_OUT_NUM; i++) begin : g_lane
        fp16_arith #(.IS_MUL(1'b1)) u_mul (
            .clk      (clk),
            .reset_b  (reset_b),
            .i_clear  (w_unit_clr),
            .i_start  (w_mul_start),
            .i_a      (r_y[16*i +: 16]),
            .i_b      ((r_state == MUL2_S) ? w_sub_res[16*i +: 16] : r_g[16*i +: 16]),
            .o_result (w_mul_res[16*i +: 16]),
            .o_valid  (w_mul_vld[i])
        );
        fp16_arith #(.IS_MUL(1'b0)) u_sub (
            .clk      (clk),
            .reset_b  (reset_b),
            .i_clear  (w_unit_clr),
            .i_start  (r_state == SUB_S),
            .i_a      (r_g[16*i +: 16]),
            .i_b      (w_neg_s),
            .o_result (w_sub_res[16*i +: 16]),
            .o_valid  (w_sub_vld[i])
        );
    end

    fp16_arith #(.IS_MUL(1'b0)) u_acc (
        .clk      (clk),
        .reset_b  (reset_b),
        .i_clear  (w_unit_clr),
        .i_start  (r_state == ACC_S),
        .i_a      (r_acc),
        .i_b      (w_acc_b),
        .o_result (w_acc_res),
        .o_valid  (w_acc_vld)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= IDLE;
            r_y         <= '0;
            r_g         <= '0;
            r_grad_out  <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_mul_all_q <= 1'b0;
            r_sub_all_q <= 1'b0;
            r_acc_vld_q <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_valid     <= 1'b0;
            r_mul_all_q <= 1'b0;
            r_sub_all_q <= 1'b0;
            r_acc_vld_q <= 1'b0;
        end else begin
            r_mul_all_q <= w_mul_all;
            r_sub_all_q <= w_sub_all;
            r_acc_vld_q <= w_acc_vld;
            r_valid     <= 1'b0;
            case (r_state)
                IDLE: if (start_op) begin
                    r_y     <= softmax_val;
                    r_g     <= grad_in_val;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= MUL1_S;
                end
                MUL1_S: r_state <= MUL1_W;
                MUL1_W: if (w_mul_edge) r_state <= ACC_S;
                ACC_S:  r_state <= ACC_W;
                ACC_W: if (w_acc_edge) begin
                    r_acc <= w_acc_res;
                    if (r_cnt == 4'(IN_OUT_NUM - 1)) begin
                        r_cnt   <= '0;
                        r_state <= SUB_S;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                        r_state <= ACC_S;
                    end
                end
                SUB_S:  r_state <= SUB_W;
                SUB_W:  if (w_sub_edge) r_state <= MUL2_S;
                MUL2_S: r_state <= MUL2_W;
                MUL2_W: if (w_mul_edge) begin
                    r_grad_out <= w_mul_res;
                    r_valid    <= 1'b1;
                    r_state    <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grad_out_val = r_grad_out;
    assign valid        = r_valid;
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
    assign busy = (r_state != IDLE);
`endif
endmodule

// File: tb/tb_fp16_softmax_grad.sv
// Scoreboard bench for fp16_softmax_grad: a 2-lane and a 1-lane instance share stimulus, FP16 reference built on reals.
module tb_fp16_softmax_grad;
    logic        clk = 1'b0;
    logic        reset_b, start_op, clear;
    logic [31:0] sm, gi, go2;
    logic [15:0] go1;
    logic        v2, v1, pv2, pv1;
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
    logic        busy2, busy1;
`endif
    logic [31:0] q2[$];
    logic [15:0] q1[$];
    logic [31:0] last2;
    logic [15:0] last1;
    int          n_vec, n_err, n_v2, n_v1;

    always #5 clk = ~clk;

    fp16_softmax_grad #(.IN_OUT_NUM(2)) u_dut2 (
        .clk(clk), .reset_b(reset_b), .start_op(start_op), .clear(clear),
        .softmax_val(sm), .grad_in_val(gi), .grad_out_val(go2), .valid(v2)
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
        , .busy(busy2)
`endif
    );

    fp16_softmax_grad #(.IN_OUT_NUM(1)) u_dut1 (
        .clk(clk), .reset_b(reset_b), .start_op(start_op), .clear(clear),
        .softmax_val(sm[15:0]), .grad_in_val(gi[15:0]), .grad_out_val(go1), .valid(v1)
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
        , .busy(busy1)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [15:0] h);
        real v;
        v = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (real'(h[14:10]) - 15.0));
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2f(input real x);
        real  a, m, fl;
        int   e;
        logic s;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 0;
        while (a >= 2.0 ** real'(e + 1)) e++;
        while (a < 2.0 ** real'(e)) e--;
        m  = a / (2.0 ** real'(e - 10));
        fl = $floor(m);
        if ((m - fl > 0.5) || ((m - fl == 0.5) && (int'(fl) % 2 == 1))) fl = fl + 1.0;
        if (fl >= 2048.0) begin
            fl = 1024.0;
            e++;
        end
        if (e + 15 >= 31) return {s, 5'h1f, 10'h0};
        if (e + 15 <= 0) return {s, 15'h0};
        return {s, 5'(e + 15), 10'(int'(fl) - 1024)};
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {a[15] ^ b[15], 15'h0};
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        real r;
        if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return {a[15] & b[15], 15'h0};
        if (a[14:10] == 5'd0) return b;
        if (b[14:10] == 5'd0) return a;
        r = f2r(a) + f2r(b);
        if (r == 0.0) return 16'h0;
        return r2f(r);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] yv, input logic [31:0] gv, input int n);
        logic [15:0] s, ns;
        logic [31:0] d;
        s = 16'h0;
        d = 32'h0;
        for (int i = 0; i < n; i++) s = m_add(s, m_mul(yv[16*i +: 16], gv[16*i +: 16]));
        ns = {~s[15], s[14:0]};
        for (int i = 0; i < n; i++) d[16*i +: 16] = m_mul(yv[16*i +: 16], m_add(gv[16*i +: 16], ns));
        return d;
    endfunction

    function automatic logic [15:0] rnd_h(input int elo, input int ehi, input bit neg_ok);
        logic [15:0] h;
        h[15]    = neg_ok ? 1'($urandom_range(1, 0)) : 1'b0;
        h[14:10] = 5'($urandom_range(ehi, elo));
        h[9:0]   = 10'($urandom);
        return h;
    endfunction

    // Called at posedge+1; start_op is taken on the next rising edge.
    task automatic kick_exp(input logic [31:0] yv, input logic [31:0] gv, input bit push,
                            input logic [31:0] e2, input logic [15:0] e1);
        sm = yv;
        gi = gv;
        start_op = 1'b1;
        if (push) begin
            q2.push_back(e2);
            q1.push_back(e1);
            last2 = e2;
            last1 = e1;
        end
        @(posedge clk); #1;
        start_op = 1'b0;
    endtask

    task automatic kick(input logic [31:0] yv, input logic [31:0] gv, input bit push);
        logic [31:0] d2, d1;
        d2 = model(yv, gv, 2);
        d1 = model({16'h0, yv[15:0]}, {16'h0, gv[15:0]}, 1);
        kick_exp(yv, gv, push, d2, d1[15:0]);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q2.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 200) begin
            check_val("timeout", 32'(q2.size() + q1.size()), 32'd0);
            q2.delete();
            q1.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (v2) begin
            n_v2++;
            check_val("vld_width2", 32'({pv2, v2}), 32'd1);
            if (q2.size() == 0) check_val("vld_unexp2", 32'(v2), 32'd0);
            else check_val("grad_out2", go2, q2.pop_front());
        end
        if (v1) begin
            n_v1++;
            check_val("vld_width1", 32'({pv1, v1}), 32'd1);
            if (q1.size() == 0) check_val("vld_unexp1", 32'(v1), 32'd0);
            else check_val("grad_out1", 32'(go1), 32'(q1.pop_front()));
        end
        pv2 = v2;
        pv1 = v1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b2, b1;
        logic [31:0] yv, gv;
        n_vec = 0; n_err = 0; n_v2 = 0; n_v1 = 0; pv2 = 0; pv1 = 0;
        last2 = '0; last1 = '0;
        reset_b = 1'b0; start_op = 1'b0; clear = 1'b0; sm = '0; gi = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out2", go2, 32'h0);
        check_val("rst_out1", 32'(go1), 32'h0);
        check_val("rst_vld", 32'({v2, v1}), 32'h0);
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
        check_val("rst_busy", 32'({busy2, busy1}), 32'h0);
`endif
        reset_b = 1'b1;
        @(posedge clk); #1;

        // y = {0.5, 0.5}, g = {1, 0}
        b2 = n_v2;
        kick_exp({16'h3800, 16'h3800}, {16'h0000, 16'h3C00}, 1'b1, 32'hB400_3400, 16'h3400);
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
        begin
            int low, n;
            low = 0;
            n = 0;
            while (!v2 && n < 100) begin
                if (!busy2) low++;
                @(posedge clk); #1;
                n++;
            end
            check_val("busy_dn", 32'(busy2), 32'd1);
            check_val("busy_op", 32'(low), 32'd0);
            @(posedge clk); #1;
            check_val("busy_idle", 32'(busy2), 32'd0);
        end
`endif
        wait_done();
        check_val("nvld_a", 32'(n_v2 - b2), 32'd1);

        kick_exp({16'h3800, 16'h3800}, {16'h3C00, 16'h3C00}, 1'b1, 32'h0000_0000, 16'h3400);
        wait_done();

        // Second start_op with new inputs lands while accumulating and must be ignored.
        b2 = n_v2; b1 = n_v1;
        kick({16'h3A00, 16'h3400}, {16'hBC00, 16'h3E00}, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        sm = 32'h3C00_3C00; gi = 32'h4000_4000; start_op = 1'b1;
        @(posedge clk); #1;
        start_op = 1'b0;
        wait_done();
        check_val("nvld_ign2", 32'(n_v2 - b2), 32'd1);
        check_val("nvld_ign1", 32'(n_v1 - b1), 32'd1);

        for (int k = 0; k < 10; k++) begin
            yv = {rnd_h(11, 14, 1'b0), rnd_h(11, 14, 1'b0)};
            gv = {rnd_h(10, 15, 1'b1), rnd_h(10, 15, 1'b1)};
            kick(yv, gv, 1'b1);
            sm = $urandom; gi = $urandom;
            wait_done();
        end

        // Abort while accumulating, then restart on the very next cycle.
        b2 = n_v2; b1 = n_v1;
        kick({16'h3600, 16'h3900}, {16'h3C00, 16'hBA00}, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        clear = 1'b1; start_op = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; start_op = 1'b0;
        check_val("clr_hold2", go2, last2);
        check_val("clr_hold1", 32'(go1), 32'(last1));
        check_val("clr_vld", 32'({v2, v1}), 32'h0);
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
        check_val("clr_busy", 32'({busy2, busy1}), 32'h0);
`endif
        kick({16'h3B00, 16'h3000}, {16'h3800, 16'hC000}, 1'b1);
        wait_done();
        check_val("nvld_clr2", 32'(n_v2 - b2), 32'd1);
        check_val("nvld_clr1", 32'(n_v1 - b1), 32'd1);

        // Reset during the subtract phase of the 2-lane instance.
        b2 = n_v2; b1 = n_v1;
        kick({16'h3800, 16'h3A00}, {16'h3C00, 16'hBE00}, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset_b = 1'b0;
        #1;
        check_val("rstm_out2", go2, 32'h0);
        check_val("rstm_out1", 32'(go1), 32'h0);
        check_val("rstm_vld", 32'({v2, v1}), 32'h0);
`ifdef FP16_SOFTMAX_GRAD_BUSY_EN
        check_val("rstm_busy", 32'({busy2, busy1}), 32'h0);
`endif
        @(posedge clk); #1;
        reset_b = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("rstm_nvld", 32'((n_v2 - b2) + (n_v1 - b1)), 32'd0);

        for (int k = 0; k < 10; k++) begin
            yv = {rnd_h(11, 14, 1'b0), rnd_h(11, 14, 1'b0)};
            gv = {rnd_h(10, 15, 1'b1), rnd_h(10, 15, 1'b1)};
            kick(yv, gv, 1'b1);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
